reg_share_arbiter: RTL and testbench

//   Round-robin write arbiter for one shared WIDTH-bit storage register (q).

---
 rtl/reg_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_reg_share_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin write arbiter for one shared WIDTH-bit register.
// NREQ requesters load q through a level req / registered one-hot gnt handshake.
// Each write is followed by a one-cycle turnaround (GRANT), so at most one
// write lands every two cycles.
// Optional feature macro: ARB_LOCK_EN adds a per-requester lock input. While the
// owner holds its lock bit, GRANT persists and q reloads from the owner each edge.
module reg_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic                  clr,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid
);

  localparam int PTRW = $clog2(NREQ);
  localparam logic [PTRW:0]     NREQ_W = NREQ[PTRW:0];
  localparam logic [PTRW-1:0]   LAST   = PTRW'(NREQ - 1);
  localparam logic [NREQ-1:0]   ONE    = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg, state_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             q_valid_reg, q_valid_next;
  logic [PTRW-1:0]  ptr_reg, ptr_next;
`ifdef ARB_LOCK_EN
  logic [PTRW-1:0]  owner_reg, owner_next;
`endif

  logic             win_found;
  logic [PTRW-1:0]  win_idx;
  logic [PTRW:0]    cand;

  // Unpacked view of the flat data bus, one slice per requester.
  logic [WIDTH-1:0] data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign data_arr[gi] = data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick: scan from ptr upward with wrap; the candidate nearest ptr
  // wins because the loop walks from farthest to nearest and overwrites.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + k[PTRW:0];
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (req[cand[PTRW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTRW-1:0];
      end
    end
  end

  // Next-state and next-output logic; everything holds unless a rule fires.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    q_next       = q_reg;
    q_valid_next = q_valid_reg;
    ptr_next     = ptr_reg;
`ifdef ARB_LOCK_EN
    owner_next   = owner_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (clr) begin
          // clear has priority; requests simply wait one more cycle
          q_next       = '0;
          q_valid_next = 1'b0;
        end else if (win_found) begin
          gnt_next     = ONE << win_idx;
          q_next       = data_arr[win_idx];
          q_valid_next = 1'b1;
          ptr_next     = (win_idx == LAST) ? '0 : win_idx + 1'b1;
          state_next   = GRANT;
`ifdef ARB_LOCK_EN
          owner_next   = win_idx;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_LOCK_EN
        if (lock[owner_reg]) begin
          // burst: owner keeps the register and rewrites it every edge
          q_next = data_arr[owner_reg];
        end else begin
          gnt_next   = '0;
          state_next = IDLE;
        end
`else
        gnt_next   = '0;
        state_next = IDLE;
`endif
      end
      default: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
      ptr_reg     <= '0;
`ifdef ARB_LOCK_EN
      owner_reg   <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      q_reg       <= q_next;
      q_valid_reg <= q_valid_next;
      ptr_reg     <= ptr_next;
`ifdef ARB_LOCK_EN
      owner_reg   <= owner_next;
`endif
    end
  end

  assign gnt     = gnt_reg;
  assign q       = q_reg;
  assign q_valid = q_valid_reg;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model of the arbitration rules.
module tb_reg_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic                  clr;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]       lock;
`endif
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;

  int cmp_count = 0;
  int err_count = 0;

  reg_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data    (data),
    .clr     (clr),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // busy = a write just happened and the register is in its hold/turnaround cycle
  logic             m_busy;
  logic [NREQ-1:0]  m_gnt;
  logic [WIDTH-1:0] m_q;
  logic             m_qv;
  int               m_ptr;
  int               m_owner;
  int               m_win;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  assign m_win = pick(req, m_ptr);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_gnt <= '0; m_q <= '0; m_qv <= 1'b0; m_ptr <= 0; m_owner <= 0;
    end else if (m_busy) begin
`ifdef ARB_LOCK_EN
      if (lock[m_owner]) m_q <= data[m_owner*WIDTH +: WIDTH];
      else begin m_busy <= 1'b0; m_gnt <= '0; end
`else
      m_busy <= 1'b0;
      m_gnt  <= '0;
`endif
    end else if (clr) begin
      m_q <= '0; m_qv <= 1'b0;
    end else if (m_win >= 0) begin
      m_busy  <= 1'b1;
      m_owner <= m_win;
      m_gnt   <= NREQ'(1) << m_win;
      m_q     <= data[m_win*WIDTH +: WIDTH];
      m_qv    <= 1'b1;
      m_ptr   <= (m_win + 1) % NREQ;
    end
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3;
    cmp_count++;
    if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0) begin
      $display("FAIL reset_init: gnt=%b q=%h qv=%b want 0000/00/0", gnt, q, q_valid); err_count++;
    end
    tick();
    reset = 1'b0;
    req = 4'b0001; data[7:0] = 8'h5A;
    tick();
    cmp_count++;
    if (gnt !== 4'b0001 || q !== 8'h5A) begin
      $display("FAIL reset_pregrant: gnt=%b q=%h want 0001/5a", gnt, q); err_count++;
    end
    #2;
    reset = 1'b1;
    #1;
    cmp_count++;
    if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0) begin
      $display("FAIL reset_async: gnt=%b q=%h qv=%b want 0000/00/0", gnt, q, q_valid); err_count++;
    end
    req = '0;
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    pulse_reset();
    tick();
    req = 4'b0001; data[7:0] = 8'hD6;
    tick();
    cmp_count++;
    if (gnt !== 4'b0001 || q !== 8'hD6 || q_valid !== 1'b1) begin
      $display("FAIL single_grant: gnt=%b q=%h qv=%b want 0001/d6/1", gnt, q, q_valid); err_count++;
    end
    req = '0;
    tick();
    cmp_count++;
    if (gnt !== 4'b0000 || q !== 8'hD6) begin
      $display("FAIL single_release: gnt=%b q=%h want 0000/d6", gnt, q); err_count++;
    end
    $display("test_single done");
  endtask

  task automatic test_all_req();
    logic [WIDTH-1:0] exp_q;
    pulse_reset();
    tick();
    data = {8'h43, 8'h32, 8'h21, 8'h10};
    req  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      exp_q = 8'h10 + 8'h11 * WIDTH'(g % 4);
      cmp_count++;
      if (gnt !== (4'b0001 << (g % 4)) || q !== exp_q) begin
        $display("FAIL rr_grant%0d: gnt=%b q=%h want idx %0d q=%h", g, gnt, q, g % 4, exp_q); err_count++;
      end
      tick();
      cmp_count++;
      if (gnt !== 4'b0000) begin
        $display("FAIL rr_gap%0d: gnt=%b want 0000", g, gnt); err_count++;
      end
    end
    req = '0;
    $display("test_all_req done");
  endtask

  task automatic test_wrap();
    pulse_reset();
    tick();
    req = 4'b0100; data[23:16] = 8'h55;
    tick();
    req = '0;
    tick();
    req = 4'b1001; data[31:24] = 8'hA3; data[7:0] = 8'hB0;
    tick();
    cmp_count++;
    if (gnt !== 4'b1000 || q !== 8'hA3) begin
      $display("FAIL wrap_first: gnt=%b q=%h want 1000/a3", gnt, q); err_count++;
    end
    tick();
    tick();
    cmp_count++;
    if (gnt !== 4'b0001 || q !== 8'hB0) begin
      $display("FAIL wrap_second: gnt=%b q=%h want 0001/b0", gnt, q); err_count++;
    end
    req = '0;
    tick();
    $display("test_wrap done");
  endtask

  task automatic test_clr();
    // q_valid is 1 from the previous test; now in IDLE
    clr = 1'b1; req = 4'b0010; data[15:8] = 8'h7E;
    tick();
    cmp_count++;
    if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0) begin
      $display("FAIL clr_edge: gnt=%b q=%h qv=%b want 0000/00/0", gnt, q, q_valid); err_count++;
    end
    clr = 1'b0;
    tick();
    cmp_count++;
    if (gnt !== 4'b0010 || q !== 8'h7E || q_valid !== 1'b1) begin
      $display("FAIL clr_after: gnt=%b q=%h qv=%b want 0010/7e/1", gnt, q, q_valid); err_count++;
    end
    req = '0;
    tick();
    $display("test_clr done");
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 8'h9C; vals[1] = 8'h11; vals[2] = 8'h22;
    pulse_reset();
    tick();
    req = 4'b0100; lock = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      data[23:16] = vals[i];
      tick();
      req = '0;
      cmp_count++;
      if (gnt !== 4'b0100 || q !== vals[i]) begin
        $display("FAIL lock_burst%0d: gnt=%b q=%h want 0100/%h", i, gnt, q, vals[i]); err_count++;
      end
    end
    lock = '0;
    tick();
    cmp_count++;
    if (gnt !== 4'b0000 || q !== 8'h22) begin
      $display("FAIL lock_exit: gnt=%b q=%h want 0000/22", gnt, q); err_count++;
    end
    $display("test_lock done");
  endtask
`endif

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      req  = NREQ'($urandom_range(0, 15));
      data = {$urandom()};
      clr  = ($urandom_range(0, 7) == 0);
`ifdef ARB_LOCK_EN
      lock = ($urandom_range(0, 2) == 0) ? NREQ'($urandom_range(0, 15)) : '0;
`endif
      tick();
      cmp_count++;
      if (gnt !== m_gnt || q !== m_q || q_valid !== m_qv) begin
        $display("FAIL rand_c%0d: gnt=%b q=%h qv=%b want %b/%h/%b", c, gnt, q, q_valid, m_gnt, m_q, m_qv);
        err_count++;
      end
    end
    req = '0; clr = 1'b0;
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    $display("test_random done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t want < 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    data  = '0;
    clr   = 1'b0;
`ifdef ARB_LOCK_EN
    lock  = '0;
`endif
    test_reset();
    test_single();
    test_all_req();
    test_wrap();
    test_clr();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
